// File: rtl/multu_hilo_if.sv
// multu_hilo_if: EX-stage bus between the instruction decoder and the
// HI/LO multiply unit.
//   valid   - funct/operands qualify this cycle (single-cycle strobe)
//   inputA  - rs operand: multiplicand, MTHI/MTLO source
//   inputB  - rt operand: multiplier
//   Signal  - 6-bit funct code shared with the ALU
//   S       - HI/LO read-back for MFHI/MFLO (combinational)
//   busy    - multiply in progress
//   done    - one-cycle pulse when HI/LO take a new product
interface multu_hilo_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic [WIDTH-1:0] inputA;
  logic [WIDTH-1:0] inputB;
  logic [5:0]       Signal;
  logic [WIDTH-1:0] S;
  logic             busy;
  logic             done;

  modport master (
    output valid, inputA, inputB, Signal,
    input  S, busy, done
  );

  modport slave (
    input  valid, inputA, inputB, Signal,
    output S, busy, done
  );
endinterface

// File: rtl/multu_hilo_unit.sv
// multu_hilo_unit: multi-cycle unsigned WIDTH x WIDTH multiplier with the
// architectural HI/LO registers. A radix-2 shift-add datapath runs WIDTH
// iterations; the 2*WIDTH-bit product lands in {HI,LO} on the last one.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - slave side of multu_hilo_if (valid/inputA/inputB/Signal in,
//            S/busy/done out)
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | accepting MULTU / MTHI / MTLO, HI/LO readable
// ST_BUSY | shift-add iterations running, new funct codes ignored
module multu_hilo_unit #(
  parameter int          WIDTH   = 32,
  parameter logic [5:0]  F_MULTU = 6'b011001,
  parameter logic [5:0]  F_MFHI  = 6'b010000,
  parameter logic [5:0]  F_MTHI  = 6'b010001,
  parameter logic [5:0]  F_MFLO  = 6'b010010,
  parameter logic [5:0]  F_MTLO  = 6'b010011
) (
  input logic         clk,
  input logic         rst_n,
  multu_hilo_if.slave bus
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  // Upper half carries one guard bit so the partial-sum carry is never lost.
  logic [2*WIDTH:0]     prod_q, prod_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [WIDTH:0]       sum;
  logic [2*WIDTH:0]     prod_next;

  // One shift-add iteration: add the multiplicand into the upper half when
  // the current multiplier LSB is set, then shift the whole thing right.
  always_comb begin
    sum       = prod_q[2*WIDTH:WIDTH] + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_next = {1'b0, sum, prod_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.valid) begin
          if (bus.Signal == F_MULTU) begin
            mcand_d = bus.inputA;
            prod_d  = {{(WIDTH+1){1'b0}}, bus.inputB};
            count_d = '0;
            busy_d  = 1'b1;
            state_d = ST_BUSY;
          end else if (bus.Signal == F_MTHI) begin
            hi_d = bus.inputA;
          end else if (bus.Signal == F_MTLO) begin
            lo_d = bus.inputA;
          end
        end
      end

      ST_BUSY: begin
        // Incoming funct codes are deliberately ignored here, including a
        // MULTU that lands on the completion edge.
        prod_d  = prod_next;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          hi_d    = prod_next[2*WIDTH-1:WIDTH];
          lo_d    = prod_next[WIDTH-1:0];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Read-back is independent of valid; the decoder stalls MFHI/MFLO while busy.
  always_comb begin
    if (bus.Signal == F_MFHI)      bus.S = hi_q;
    else if (bus.Signal == F_MFLO) bus.S = lo_q;
    else                           bus.S = '0;
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_multu_hilo_unit.sv
module tb_multu_hilo_unit;

  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multu_hilo_if #(.WIDTH(32)) bus ();

  multu_hilo_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Reference model: architectural HI/LO plus when the pending product lands.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  bit          m_busy = 1'b0;
  int          m_done_edge = 0;
  logic [63:0] m_pend = '0;

  int          exp_done_q[$];
  logic [31:0] exp_rd_q[$];
  string       rd_name_q[$];
  bit          rd_req = 1'b0;

  task automatic step();
    @(posedge clk);
    edge_n++;
    if (m_busy && edge_n == m_done_edge) begin
      {m_hi, m_lo} = m_pend;
      m_busy = 1'b0;
    end
    #1;
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bit idle;
    idle = !m_busy;
    bus.valid  = 1'b1;
    bus.Signal = f;
    bus.inputA = a;
    bus.inputB = b;
    step();
    if (idle) begin
      if (f == F_MULTU) begin
        m_busy      = 1'b1;
        m_done_edge = edge_n + 32;
        m_pend      = 64'(a) * 64'(b);
        exp_done_q.push_back(m_done_edge);
      end else if (f == F_MTHI) begin
        m_hi = a;
      end else if (f == F_MTLO) begin
        m_lo = a;
      end
    end
    bus.valid = 1'b0;
  endtask

  task automatic read(input logic [5:0] f, input logic [31:0] exp, input string nm);
    bus.valid  = 1'b0;
    bus.Signal = f;
    exp_rd_q.push_back(exp);
    rd_name_q.push_back(nm);
    rd_req = 1'b1;
    step();
  endtask

  task automatic wait_idle();
    while (m_busy) step();
    step();
  endtask

  task automatic check_hilo(input string nm);
    read(F_MFHI, m_hi, {nm, "_hi"});
    read(F_MFLO, m_lo, {nm, "_lo"});
  endtask

  // Monitor: compares DUT outputs against the model/scoreboard on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (bus.busy !== m_busy) begin
        errors++;
        $display("FAIL busy @edge %0d: got %b expected %b", edge_n, bus.busy, m_busy);
      end
      if (bus.done === 1'b1) begin
        checks++;
        if (exp_done_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done @edge %0d: got 1 expected 0", edge_n);
        end else begin
          int e;
          e = exp_done_q.pop_front();
          if (e != edge_n) begin
            errors++;
            $display("FAIL done_edge: got edge %0d expected edge %0d", edge_n, e);
          end
        end
      end else if (exp_done_q.size() > 0 && edge_n >= exp_done_q[0]) begin
        checks++;
        errors++;
        $display("FAIL missing_done: got none by edge %0d expected at edge %0d", edge_n, exp_done_q[0]);
        void'(exp_done_q.pop_front());
      end
      if (rd_req) begin
        logic [31:0] e;
        string nm;
        e  = exp_rd_q.pop_front();
        nm = rd_name_q.pop_front();
        rd_req = 1'b0;
        checks++;
        if (bus.S !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h", nm, bus.S, e);
        end
      end
    end
  end

  initial begin
    bus.valid  = 1'b0;
    bus.Signal = '0;
    bus.inputA = '0;
    bus.inputB = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
    check_hilo("reset");

    // 3 * 5
    issue(F_MULTU, 32'd3, 32'd5);
    wait_idle();
    read(F_MFHI, 32'h0000_0000, "mul3x5_hi");
    read(F_MFLO, 32'h0000_000F, "mul3x5_lo");

    // Max operands: carry through the guard bit
    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
    read(F_MFHI, 32'hFFFF_FFFE, "mulmax_hi");
    read(F_MFLO, 32'h0000_0001, "mulmax_lo");

    // 2^16 * 2^16, then MTLO leaves HI alone
    issue(F_MULTU, 32'h0001_0000, 32'h0001_0000);
    wait_idle();
    read(F_MFHI, 32'h0000_0001, "mul2p32_hi");
    read(F_MFLO, 32'h0000_0000, "mul2p32_lo");
    issue(F_MTLO, 32'h1234_5678, 32'h0);
    read(F_MFLO, 32'h1234_5678, "mtlo_lo");
    read(F_MFHI, 32'h0000_0001, "mtlo_hi_kept");

    // 7 * 9 with ignored MULTU/MTHI mid-run and stale reads during BUSY
    issue(F_MULTU, 32'd7, 32'd9);
    for (int i = 0; i < 9; i++) step();
    issue(F_MULTU, 32'd2, 32'd2);
    issue(F_MTHI, 32'hDEAD_BEEF, 32'h0);
    read(F_MFHI, 32'h0000_0001, "busy_stale_hi");
    read(F_MFLO, 32'h1234_5678, "busy_stale_lo");
    wait_idle();
    read(F_MFHI, 32'h0000_0000, "mul7x9_hi");
    read(F_MFLO, 32'h0000_003F, "mul7x9_lo");

    // MULTU on the completion edge is dropped
    issue(F_MULTU, 32'd11, 32'd13);
    while (edge_n + 1 < m_done_edge) step();
    issue(F_MULTU, 32'd5, 32'd5);
    step();
    read(F_MFLO, 32'd143, "edge_multu_ignored");

    // Reset mid-multiply
    issue(F_MULTU, 32'h8000_0000, 32'd2);
    for (int i = 0; i < 15; i++) step();
    rst_n = 1'b0;
    m_busy = 1'b0;
    m_hi = '0;
    m_lo = '0;
    exp_done_q.delete();
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    check_hilo("after_reset");
    issue(F_MULTU, 32'd6, 32'd7);
    wait_idle();
    read(F_MFLO, 32'h0000_002A, "mul6x7_lo");

    // ALU funct is a no-op for this unit
    issue(F_ADD, 32'hAAAA_5555, 32'h1);
    read(F_ADD, 32'h0, "s_add_zero");
    check_hilo("add_noop");

    // Randomized traffic with interference while busy
    for (int n = 0; n < 25; n++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'hFFFF_FFFF;
        1: b = 32'h0;
        2: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      issue(F_MULTU, a, b);
      while (m_busy) begin
        case ($urandom_range(0, 9))
          0: issue(F_MULTU, $urandom, $urandom);
          1: issue(F_MTHI, $urandom, 32'h0);
          2: issue(F_MTLO, $urandom, 32'h0);
          3: read(F_MFHI, m_hi, "rnd_busy_hi");
          4: read(F_MFLO, m_lo, "rnd_busy_lo");
          default: step();
        endcase
      end
      check_hilo("rnd_prod");
      if ($urandom_range(0, 2) == 0) begin
        issue(F_MTHI, $urandom, 32'h0);
        issue(F_MTLO, $urandom, 32'h0);
        check_hilo("rnd_mt");
      end
    end

    step();
    step();
    checks++;
    if (exp_done_q.size() != 0) begin
      errors++;
      $display("FAIL done_outstanding: got %0d pending expected 0", exp_done_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multu_hilo_unit.md
Name: multu_hilo_unit

Overview:
- Multi-cycle unsigned 32x32 multiplier with architectural HI/LO registers. Sits in the EX stage alongside the 32-bit ALU.
- Decodes the same 6-bit funct Signal the ALU uses.
- Produces a 64-bit product into HI/LO via a radix-2 shift-add datapath over 32 iterations.
- Returns HI or LO on S for MFHI/MFLO; the EX result mux consumes that value next to the ALU result.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH each, the product is 2*WIDTH.
- F_MULTU, 6'b011001, funct code that starts a multiply.
- F_MFHI, 6'b010000, funct code that reads HI.
- F_MTHI, 6'b010001, funct code that writes HI.
- F_MFLO, 6'b010010, funct code that reads LO.
- F_MTLO, 6'b010011, funct code that writes LO.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- valid  in  1  Signal/operands qualify this cycle; single-cycle strobe per instruction.
- inputA  in  WIDTH  rs operand; multiplicand; MTHI/MTLO source.
- inputB  in  WIDTH  rt operand; multiplier.
- Signal  in  6  funct code.
- S  out  WIDTH  combinational read: HI when Signal==F_MFHI, LO when Signal==F_MFLO, else 0.
- busy  out  1  multiply in progress; the decoder stalls the pipe on MFHI/MFLO/MULTU while high.
- done  out  1  one-cycle pulse when HI/LO take a new product.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; HI=0, LO=0, multiplicand=0, product=0, count=0, busy=0, done=0.
- States: IDLE, BUSY.
- IDLE plus valid plus F_MULTU at edge k:
  - multiplicand<=inputA, product<={33'b0, inputB[31:0]} (65-bit, 1 guard bit), count<=0, state<=BUSY.
  - busy=1 from after edge k.
- BUSY, each edge:
  - sum = product[64:32] + (product[0] ? {1'b0,multiplicand} : 0), computed 33-bit.
  - product<={sum, product[31:1]} >> 0, i.e. product <= {sum[32:0], product[31:1]} taken as 65 bits, which is a logical shift right with the carry kept.
  - count<=count+1.
- Completion on the 32nd BUSY edge (edge k+32):
  - {HI,LO}<= the new 64-bit product (bits 63:0), state<=IDLE.
  - done=1 for exactly the cycle after edge k+32; busy=0 from that same cycle.
  - Total latency is 32 cycles from the accepting edge.
- HI/LO stay stable during BUSY; MFHI/MFLO during BUSY return the previous values (the decoder must stall).
- MTHI/MTLO with valid in IDLE: HI (or LO)<=inputA at the edge. The other register is unchanged.
- Any valid funct while BUSY: MULTU, MTHI and MTLO are ignored; no restart and no write.
- Simultaneous completion edge and valid MULTU: the MULTU is ignored. It is accepted only when sampled in IDLE (next cycle at the earliest).
- valid with any other funct (ALU ops): no state change.
- done is 0 except on the single completion cycle.
- rst_n low mid-multiply aborts immediately: all registers return to reset values, no done pulse. After release the unit is IDLE.
- Arithmetic is unsigned only; no overflow (the 64-bit product always fits).

Test Plan:
- Reset then valid MULTU A=3 B=5 -> busy 32 cycles; done pulse on cycle 33 after the accepting edge; MFHI=0x00000000, MFLO=0x0000000F.
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; guard bit carry path exercised.
- MULTU A=0x00010000 B=0x00010000 -> HI=0x00000001, LO=0x00000000. Then MTLO inputA=0x12345678 -> LO=0x12345678, HI still 0x00000001.
- Start MULTU 7*9. At cycle 10 of BUSY, issue valid MULTU 2*2 and MTHI 0xDEADBEEF -> both ignored. During BUSY, MFHI reads the previous HI. Final HI=0, LO=0x3F.
- Start MULTU 0x80000000*2. Assert rst_n=0 at BUSY cycle 16 -> busy=0, done never pulses, HI=LO=0. A new MULTU 6*7 after release gives LO=0x2A.
- valid with Signal=6'b100000 (ADD) in IDLE -> no busy, S=0, HI/LO unchanged.
